data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master, two-slave data-bus controller placed between the requesters and the data-side devices: the core's load/store port, a second master such as a debug or DMA loader, the dual-port load memory, and the data memory. It arbitrates round-robin between the masters and decodes the address to one slave. It then sequences a single transaction through an IDLE/ACCESS/RESP state machine and returns read data with a completion or error response. It replaces the ad-hoc select-based read mux, so only one device is driven per transaction.

## Interface
- MMIO_BASE_DLM, 32'h8000_0000, base address of the dual-load memory region
- MMIO_MASK_DLM, 32'hFFFF_FF00, address match mask for the DLM region
- MMIO_BASE_MEM, 32'h9000_0000, base address of the data memory region
- MMIO_MASK_MEM, 32'hFFFF_FF00, address match mask for the data memory region
- TIMEOUT_CYCLES, 15, ACCESS cycles without slave ready before an error response (1..255)
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- m0_req / m1_req  in  1  master requests a transaction
- m0_addr / m1_addr  in  32  transaction address
- m0_wdata / m1_wdata  in  32  write data
- m0_wen / m1_wen  in  1  1 = write, 0 = read
- m0_gnt / m1_gnt  out  1  request accepted; request fields are captured on this cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid with rvalid
- m0_err / m1_err  out  1  error flag, valid with rvalid
- s_addr, s_wdata  out  32  registered transaction address and data to the slaves
- s_wen  out  1  registered write strobe; qualified by the slave request
- s_dlm_req / s_mem_req  out  1  per-slave request, one-hot or zero
- s_dlm_ready / s_mem_ready  in  1  slave has completed the access
- s_dlm_rdata / s_mem_rdata  in  32  slave read data, sampled when ready

## Operation
- The state machine has three states: IDLE, ACCESS and RESP.
- **IDLE behaviour:**
  - If any request is high, choose a winner and drive its gnt high combinationally in that cycle.
  - At the clock edge, capture addr, wdata and wen, the owner index, and the decode result.
  - On a decode hit, move to ACCESS. On a decode miss, move to RESP with err=1.
- **Arbitration:**
  - A lone request always wins.
  - When both masters request, the master that did not win last wins.
  - The pointer updates only on a grant.
  - After reset, m0 has priority.
- **Decode:**
  - DLM hit when (addr & MMIO_MASK_DLM) == MMIO_BASE_DLM.
  - MEM hit when (addr & MMIO_MASK_MEM) == MMIO_BASE_MEM.
  - DLM wins if both regions match.
  - Any other address is a decode miss.
- **ACCESS behaviour:**
  - Hold the selected s_*_req high along with stable s_addr, s_wdata and s_wen.
  - On the selected slave's ready, latch its rdata (forced to 0 for writes), drop the request and move to RESP with err=0.
  - The ready input of the unselected slave is ignored.
- **RESP behaviour:**
  - Pulse the owner's rvalid for one cycle, with the latched rdata and err; then return to IDLE.
  - The non-owner's rvalid, rdata and err stay 0.
- **Error responses:** rdata is 0 on any error.
- **Master protocol:**
  - A master holds req and its fields stable until it sees gnt, then may deassert.
  - A request that remains high after rvalid is a new transaction.
- **Reset:**
  - All outputs reset to 0, the state goes to IDLE, and the pointer resets to m0 priority.
  - A reset during ACCESS or RESP abandons the transaction with no rvalid.

## Timing
- **Grant:** the grant appears in the same cycle as req (cycle 0), provided the arbiter is in IDLE.
- **Minimum latency (slave ready in the first ACCESS cycle):**
  - Cycle 1: ACCESS.
  - Cycle 2: RESP with rvalid.
  - Cycle 3: IDLE, which can grant again.
- **Decode miss:** RESP in cycle 1.
- **Back-to-back:** throughput is one transaction per 3 cycles at best.
- **No grant outside IDLE:** no gnt is issued in ACCESS or RESP; requests wait.
- **Timeout counter:** the 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle without ready.
- **Timeout expiry:** when the count equals TIMEOUT_CYCLES - 1 and ready is still low, the next state is RESP with err=1. The slave request drops on that same edge.
- **Ready on the last cycle:** ready arriving on the final counted cycle takes precedence, giving a normal completion.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - The timeout counter and the timeout error path are compiled in, as above.
  - TIMEOUT_CYCLES is honoured.
- **ARB_TIMEOUT_EN undefined:**
  - The counter is absent and ACCESS waits indefinitely for ready.
  - err is raised only on a decode miss.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- **m0 read:** m0 reads 0x8000_0010; s_dlm_ready is high in the first ACCESS cycle with rdata 0xDEADBEEF.
  - m0_gnt in cycle 0, s_dlm_req in cycle 1, then m0_rvalid, rdata 0xDEADBEEF and err 0 in cycle 2.
- **Simultaneous requests after reset:** m0 and m1 both request continuously.
  - Grants alternate m0, m1, m0, m1, with each rvalid going only to the owner.
- **m1 write:** m1 writes 0x1234_5678 to 0x9000_0004 and s_mem_ready arrives 3 cycles late.
  - s_mem_req is held for 4 cycles, s_wen=1 with stable data, then m1_rvalid with err 0 and rdata 0.
- **Decode miss:** a read of 0x0000_0000.
  - No slave request; rvalid with err 1 and rdata 0 in cycle 1.
- **Timeout (ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4):** slave ready is never asserted.
  - s_dlm_req is high for exactly 4 cycles, then rvalid with err 1.
  - With the macro undefined, the request stays high indefinitely.
- **Reset mid-transaction:** rst is asserted in the second ACCESS cycle.
  - The next cycle shows all outputs 0 and no rvalid.
  - A following simultaneous request is granted to m0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master, two-slave data-bus arbiter with round-robin grant, address decode and IDLE/ACCESS/RESP sequencing.
// Define ARB_TIMEOUT_EN to compile in the ACCESS timeout counter and its error response.
module data_bus_arbiter #(
  parameter logic [31:0] MMIO_BASE_DLM  = 32'h8000_0000,
  parameter logic [31:0] MMIO_MASK_DLM  = 32'hFFFF_FF00,
  parameter logic [31:0] MMIO_BASE_MEM  = 32'h9000_0000,
  parameter logic [31:0] MMIO_MASK_MEM  = 32'hFFFF_FF00,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_wen,
  output logic        s_dlm_req,
  output logic        s_mem_req,
  input  logic        s_dlm_ready,
  input  logic [31:0] s_dlm_rdata,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic        s_wen_q, s_wen_d;
  logic        s_dlm_req_q, s_dlm_req_d;
  logic        s_mem_req_q, s_mem_req_d;
  logic        m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
`ifdef ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic        winner, grant_ok, dlm_hit, mem_hit, sel_wen, sel_ready;
  logic [31:0] sel_addr, sel_wdata, sel_rdata;
  logic        resp_valid, resp_owner, resp_err;
  logic [31:0] resp_data;

  // prio_q names the master that wins a tie; a lone request always wins.
  always_comb begin
    winner    = (m0_req && m1_req) ? prio_q : m1_req;
    grant_ok  = (state_q == IDLE) && !rst && (m0_req || m1_req);
    m0_gnt    = grant_ok && !winner;
    m1_gnt    = grant_ok && winner;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
    sel_wen   = winner ? m1_wen   : m0_wen;
    dlm_hit   = (sel_addr & MMIO_MASK_DLM) == MMIO_BASE_DLM;
    mem_hit   = ((sel_addr & MMIO_MASK_MEM) == MMIO_BASE_MEM) && !dlm_hit;
    sel_ready = s_dlm_req_q ? s_dlm_ready : s_mem_ready;
    sel_rdata = s_dlm_req_q ? s_dlm_rdata : s_mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wen_d     = s_wen_q;
    s_dlm_req_d = s_dlm_req_q;
    s_mem_req_d = s_mem_req_q;
    m0_rvalid_d = m0_rvalid_q;
    m0_rdata_d  = m0_rdata_q;
    m0_err_d    = m0_err_q;
    m1_rvalid_d = m1_rvalid_q;
    m1_rdata_d  = m1_rdata_q;
    m1_err_d    = m1_err_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    resp_valid  = 1'b0;
    resp_owner  = owner_q;
    resp_err    = 1'b0;
    resp_data   = 32'h0;

    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          owner_d   = winner;
          prio_d    = ~winner;
          s_addr_d  = sel_addr;
          s_wdata_d = sel_wdata;
          s_wen_d   = sel_wen;
          if (dlm_hit || mem_hit) begin
            state_d     = ACCESS;
            s_dlm_req_d = dlm_hit;
            s_mem_req_d = mem_hit;
`ifdef ARB_TIMEOUT_EN
            cnt_d       = 8'd0;
`endif
          end else begin
            state_d    = RESP;
            resp_valid = 1'b1;
            resp_owner = winner;
            resp_err   = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = RESP;
          s_dlm_req_d = 1'b0;
          s_mem_req_d = 1'b0;
          resp_valid  = 1'b1;
          resp_data   = s_wen_q ? 32'h0 : sel_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        // Ready on the last counted cycle wins over expiry.
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          s_dlm_req_d = 1'b0;
          s_mem_req_d = 1'b0;
          resp_valid  = 1'b1;
          resp_err    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        state_d     = IDLE;
        m0_rvalid_d = 1'b0;
        m0_rdata_d  = 32'h0;
        m0_err_d    = 1'b0;
        m1_rvalid_d = 1'b0;
        m1_rdata_d  = 32'h0;
        m1_err_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (resp_valid) begin
      if (resp_owner) begin
        m1_rvalid_d = 1'b1;
        m1_rdata_d  = resp_data;
        m1_err_d    = resp_err;
      end else begin
        m0_rvalid_d = 1'b1;
        m0_rdata_d  = resp_data;
        m0_err_d    = resp_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      s_addr_q    <= 32'h0;
      s_wdata_q   <= 32'h0;
      s_wen_q     <= 1'b0;
      s_dlm_req_q <= 1'b0;
      s_mem_req_q <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m0_err_q    <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m1_rdata_q  <= 32'h0;
      m1_err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wen_q     <= s_wen_d;
      s_dlm_req_q <= s_dlm_req_d;
      s_mem_req_q <= s_mem_req_d;
      m0_rvalid_q <= m0_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m0_err_q    <= m0_err_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_rdata_q  <= m1_rdata_d;
      m1_err_q    <= m1_err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wen     = s_wen_q;
  assign s_dlm_req = s_dlm_req_q;
  assign s_mem_req = s_mem_req_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed transactions, scoreboard of expected responses.
// The timeout scenario follows ARB_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES=4).
module tb_data_bus_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_wen, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wen, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] s_addr, s_wdata;
  logic        s_wen, s_dlm_req, s_mem_req, s_dlm_ready, s_mem_ready;
  logic [31:0] s_dlm_rdata, s_mem_rdata;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t expQueue[$];
  int   passCount  = 0;
  int   checkCount = 0;

  data_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wen(m0_wen),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wen(m1_wen),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen),
    .s_dlm_req(s_dlm_req), .s_mem_req(s_mem_req),
    .s_dlm_ready(s_dlm_ready), .s_dlm_rdata(s_dlm_rdata),
    .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic master, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic wen);
    if (master) begin
      m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wen = wen;
    end else begin
      m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wen = wen;
    end
  endtask

  task automatic pushExpected(input logic owner, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.owner = owner; e.rdata = rdata; e.err = err;
    expQueue.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic resetDut();
    tick();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    s_dlm_ready = 1'b0; s_mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: every response the DUT presents is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (m0_rvalid || m1_rvalid)) begin
      exp_t e;
      checkOutput("sb_rvalid_onehot", 32'(m0_rvalid & m1_rvalid), 32'h0);
      if (expQueue.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL sb_unexpected_rvalid: got m0=%0b m1=%0b expected none", m0_rvalid, m1_rvalid);
      end else begin
        e = expQueue.pop_front();
        checkOutput("sb_owner", 32'(m1_rvalid), 32'(e.owner));
        checkOutput("sb_rdata", m1_rvalid ? m1_rdata : m0_rdata, e.rdata);
        checkOutput("sb_err", 32'(m1_rvalid ? m1_err : m0_err), 32'(e.err));
        checkOutput("sb_nonowner_rdata", m1_rvalid ? m0_rdata : m1_rdata, 32'h0);
        checkOutput("sb_nonowner_err", 32'(m1_rvalid ? m0_err : m1_err), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_wen = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0;
    s_dlm_ready = 0; s_mem_ready = 0; s_dlm_rdata = 0; s_mem_rdata = 0;
    resetDut();

    sample();
    checkOutput("rst_gnt", {m0_gnt, m1_gnt}, 32'h0);
    checkOutput("rst_rvalid", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'h0);
    checkOutput("rst_sreq", {s_dlm_req, s_mem_req, s_wen}, 32'h0);
    checkOutput("rst_saddr", s_addr, 32'h0);
    checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'h0);

    // m0 read from DLM with ready in the first ACCESS cycle
    tick();
    applyStimulus(1'b0, 32'h8000_0010, 32'h0, 1'b0);
    sample();
    checkOutput("t1_m0_gnt", 32'(m0_gnt), 32'h1);
    checkOutput("t1_m1_gnt", 32'(m1_gnt), 32'h0);
    pushExpected(1'b0, 32'hDEAD_BEEF, 1'b0);
    tick();
    m0_req = 1'b0; s_dlm_ready = 1'b1; s_dlm_rdata = 32'hDEAD_BEEF;
    sample();
    checkOutput("t1_dlm_req", {s_dlm_req, s_mem_req}, 32'h2);
    checkOutput("t1_saddr", s_addr, 32'h8000_0010);
    checkOutput("t1_swen", 32'(s_wen), 32'h0);
    tick();
    s_dlm_ready = 1'b0;
    sample();
    checkOutput("t1_rvalid", 32'(m0_rvalid), 32'h1);
    checkOutput("t1_dlm_req_drop", 32'(s_dlm_req), 32'h0);
    tick();
    sample();
    checkOutput("t1_rvalid_pulse", 32'(m0_rvalid), 32'h0);

    // Both masters request continuously after reset: grants alternate from m0
    resetDut();
    s_dlm_ready = 1'b1; s_dlm_rdata = 32'h1111_1111;
    s_mem_ready = 1'b1; s_mem_rdata = 32'h2222_2222;
    applyStimulus(1'b0, 32'h8000_0020, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h9000_0008, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic expM1;
      expM1 = (i % 2) == 1;
      sample();
      checkOutput($sformatf("t2_gnt%0d", i), {m0_gnt, m1_gnt}, expM1 ? 32'h1 : 32'h2);
      pushExpected(expM1, expM1 ? 32'h2222_2222 : 32'h1111_1111, 1'b0);
      tick();
      if (i == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
      sample();
      checkOutput($sformatf("t2_nognt_access%0d", i), {m0_gnt, m1_gnt}, 32'h0);
      tick();
      sample();
      checkOutput($sformatf("t2_nognt_resp%0d", i), {m0_gnt, m1_gnt}, 32'h0);
      tick();
    end
    s_dlm_ready = 1'b0; s_mem_ready = 1'b0;

    // m1 write to MEM with ready three cycles late; write returns rdata 0
    applyStimulus(1'b1, 32'h9000_0004, 32'h1234_5678, 1'b1);
    sample();
    checkOutput("t3_m1_gnt", {m0_gnt, m1_gnt}, 32'h1);
    pushExpected(1'b1, 32'h0, 1'b0);
    tick();
    m1_req = 1'b0; s_mem_rdata = 32'hAAAA_AAAA;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) s_mem_ready = 1'b1;
      sample();
      checkOutput($sformatf("t3_mem_req%0d", k), {s_dlm_req, s_mem_req}, 32'h1);
      checkOutput($sformatf("t3_swen%0d", k), 32'(s_wen), 32'h1);
      checkOutput($sformatf("t3_swdata%0d", k), s_wdata, 32'h1234_5678);
      checkOutput($sformatf("t3_saddr%0d", k), s_addr, 32'h9000_0004);
      tick();
    end
    s_mem_ready = 1'b0;
    sample();
    checkOutput("t3_m1_rvalid", {m0_rvalid, m1_rvalid}, 32'h1);
    checkOutput("t3_mem_req_drop", 32'(s_mem_req), 32'h0);
    tick();

    // Decode miss responds in the cycle after grant with err
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    sample();
    checkOutput("t4_m0_gnt", {m0_gnt, m1_gnt}, 32'h2);
    pushExpected(1'b0, 32'h0, 1'b1);
    tick();
    m0_req = 1'b0;
    sample();
    checkOutput("t4_rvalid", 32'(m0_rvalid), 32'h1);
    checkOutput("t4_no_sreq", {s_dlm_req, s_mem_req}, 32'h0);
    tick();

    // Slave never ready
    applyStimulus(1'b0, 32'h8000_0040, 32'h0, 1'b0);
    sample();
    checkOutput("t5_m0_gnt", 32'(m0_gnt), 32'h1);
`ifdef ARB_TIMEOUT_EN
    pushExpected(1'b0, 32'h0, 1'b1);
    tick();
    m0_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      checkOutput($sformatf("t5_dlm_req%0d", k), 32'(s_dlm_req), 32'h1);
      tick();
    end
    sample();
    checkOutput("t5_dlm_req_drop", 32'(s_dlm_req), 32'h0);
    checkOutput("t5_rvalid", 32'(m0_rvalid), 32'h1);
    tick();
`else
    pushExpected(1'b0, 32'h5555_AAAA, 1'b0);
    tick();
    m0_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      checkOutput($sformatf("t5_dlm_req%0d", k), 32'(s_dlm_req), 32'h1);
      tick();
    end
    s_dlm_ready = 1'b1; s_dlm_rdata = 32'h5555_AAAA;
    sample();
    checkOutput("t5_dlm_req_held", 32'(s_dlm_req), 32'h1);
    tick();
    s_dlm_ready = 1'b0;
    sample();
    checkOutput("t5_rvalid", 32'(m0_rvalid), 32'h1);
    tick();
`endif

    // Reset in the second ACCESS cycle abandons the transaction
    applyStimulus(1'b0, 32'h8000_0080, 32'h0, 1'b0);
    sample();
    checkOutput("t6_m0_gnt", 32'(m0_gnt), 32'h1);
    tick();
    m0_req = 1'b0;
    sample();
    checkOutput("t6_access1", 32'(s_dlm_req), 32'h1);
    tick();
    rst = 1'b1;
    sample();
    tick();
    rst = 1'b0;
    sample();
    checkOutput("t6_after_rst_valid", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'h0);
    checkOutput("t6_after_rst_sreq", {s_dlm_req, s_mem_req, s_wen, m0_gnt, m1_gnt}, 32'h0);
    checkOutput("t6_after_rst_saddr", s_addr, 32'h0);
    tick();
    s_dlm_ready = 1'b1; s_dlm_rdata = 32'h0F0F_0F0F;
    applyStimulus(1'b0, 32'h8000_00C0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h9000_00C0, 32'h0, 1'b0);
    sample();
    checkOutput("t6_tie_gnt", {m0_gnt, m1_gnt}, 32'h2);
    pushExpected(1'b0, 32'h0F0F_0F0F, 1'b0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    tick();
    s_dlm_ready = 1'b0;
    repeat (3) tick();

    sample();
    checkOutput("sb_drained", 32'(expQueue.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
